// File: rtl/move_key_tracker_if.sv
// Byte-in / movement-out bundle between the PS/2 byte receiver and the movement tracker.
// Latency: n/a (wires only).
// Backpressure: none; scan_valid is a one-cycle strobe and the tracker always accepts it.
// Signals: scan_code/scan_valid (receiver -> tracker), dir/step/attack/held (tracker -> player logic).
interface move_key_tracker_if;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic [2:0] dir;
  logic       step;
  logic       attack;
  logic [4:0] held;

  // master: byte source that also observes the movement outputs
  modport master (
    output scan_code, scan_valid,
    input  dir, step, attack, held
  );

  // slave: the tracker itself
  modport slave (
    input  scan_code, scan_valid,
    output dir, step, attack, held
  );
endinterface

// File: rtl/move_key_tracker.sv
// PS/2 set-2 decoder tracking 4 direction keys + attack, producing dir level, auto-repeat step and attack strobes.
// Latency: final byte of a make/break -> held/dir/step/attack update 1 cycle later.
// Backpressure: none; every scan_valid byte is consumed the cycle it arrives.
// Ports: clk, reset (async, active-high); bus.slave: scan_code/scan_valid in, dir[2:0]/step/attack/held[4:0] out.
module move_key_tracker #(
  parameter int         REPEAT_DELAY  = 12_500_000,
  parameter int         REPEAT_PERIOD = 5_000_000,
  parameter bit         ACCEPT_KEYPAD = 1'b1,
  parameter logic [7:0] ATTACK_CODE   = 8'h1A
) (
  input  logic               clk,
  input  logic               reset,
  move_key_tracker_if.slave  bus
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DELAY_LD  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] PERIOD_LD = CW'(REPEAT_PERIOD);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t        state, state_nxt;
  logic          ev_make, ev_brk, ev_ext;
  logic [4:0]    key;           // one-hot {attack,right,down,left,up} of the final byte
  logic [4:0]    held_q, held_after;
  logic [2:0]    dir_q, fallback;
  logic          step_q, attack_q;
  logic [CW-1:0] cnt_q;
  logic          key_new, key_gone, dir_press, dir_release;

  // One-hot (or multi-hot) key set -> direction code, priority up > down > left > right.
  // Used both to encode a single pressed key and to pick the fallback among remaining held keys.
  function automatic logic [2:0] dir_code(input logic [3:0] k);
    logic [2:0] d;
    d = 3'b000;
    if (k[0])      d = 3'b010;
    else if (k[2]) d = 3'b100;
    else if (k[1]) d = 3'b001;
    else if (k[3]) d = 3'b011;
    return d;
  endfunction

  // Prefix decoder: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Prefix decoder: next state and make/break event for the final byte
  always_comb begin
    state_nxt = state;
    ev_make   = 1'b0;
    ev_brk    = 1'b0;
    ev_ext    = 1'b0;
    if (bus.scan_valid) begin
      case (state)
        S_IDLE: begin
          if (bus.scan_code == 8'hE0)      state_nxt = S_EXT;
          else if (bus.scan_code == 8'hF0) state_nxt = S_BRK;
          else begin ev_make = 1'b1; state_nxt = S_IDLE; end
        end
        S_EXT: begin
          if (bus.scan_code == 8'hF0)      state_nxt = S_EXT_BRK;
          else if (bus.scan_code == 8'hE0) state_nxt = S_EXT;
          else begin ev_make = 1'b1; ev_ext = 1'b1; state_nxt = S_IDLE; end
        end
        S_BRK: begin
          // E0 after F0 means we lost sync; restart as an extended sequence
          if (bus.scan_code == 8'hE0)      state_nxt = S_EXT;
          else if (bus.scan_code == 8'hF0) state_nxt = S_BRK;
          else begin ev_brk = 1'b1; state_nxt = S_IDLE; end
        end
        S_EXT_BRK: begin
          if (bus.scan_code == 8'hE0)      state_nxt = S_EXT;
          else if (bus.scan_code == 8'hF0) state_nxt = S_EXT_BRK;
          else begin ev_brk = 1'b1; ev_ext = 1'b1; state_nxt = S_IDLE; end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Key mapping; keypad and arrow variants share a held bit
  always_comb begin
    key = 5'b00000;
    if (ev_ext || ACCEPT_KEYPAD) begin
      case (bus.scan_code)
        8'h75:   key = 5'b00001;
        8'h6B:   key = 5'b00010;
        8'h72:   key = 5'b00100;
        8'h74:   key = 5'b01000;
        default: key = 5'b00000;
      endcase
    end
    if (!ev_ext && bus.scan_code == ATTACK_CODE) key = 5'b10000;
  end

  assign key_new     = ev_make && (key != 5'b0) && ((held_q & key) == 5'b0);
  assign key_gone    = ev_brk && ((held_q & key) != 5'b0);
  assign held_after  = held_q & ~key;
  assign fallback    = dir_code(held_after[3:0]);
  assign dir_press   = key_new && !key[4];
  // Only releasing the key that currently owns dir moves dir; other releases just clear held
  assign dir_release = key_gone && !key[4] && (dir_code(key[3:0]) == dir_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_q   <= 5'b0;
      dir_q    <= 3'b000;
      step_q   <= 1'b0;
      attack_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      step_q   <= 1'b0;
      attack_q <= key_new && key[4];

      if (key_new)       held_q <= held_q | key;
      else if (key_gone) held_q <= held_after;

      // A direction scan event overrides a repeat expiry in the same cycle,
      // so at most one step strobe is ever produced per cycle.
      if (dir_press) begin
        dir_q  <= dir_code(key[3:0]);
        step_q <= 1'b1;
        cnt_q  <= DELAY_LD;
      end else if (dir_release) begin
        dir_q <= fallback;
        cnt_q <= (fallback == 3'b000) ? '0 : DELAY_LD;
      end else if (dir_q == 3'b000) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_ONE) begin
        step_q <= 1'b1;
        cnt_q  <= PERIOD_LD;
      end else begin
        cnt_q <= cnt_q - CNT_ONE;
      end
    end
  end

  assign bus.dir    = dir_q;
  assign bus.step   = step_q;
  assign bus.attack = attack_q;
  assign bus.held   = held_q;

endmodule
